chip8_prog_loader: RTL and testbench

Program loader that writes a CHIP-8 program image into the CPU's 3328-byte program memory before execution. It accepts a framed byte stream over a valid/ready interface: 16-bit length, payload, 8-bit checksum. It writes each payload byte to consecutive addresses, then zero-fills the rest of memory. The CPU fetch side is held off until the image is verified.

---
 rtl/chip8_pkg.sv | 29 ++
 rtl/chip8_csum8.sv | 21 ++
 rtl/chip8_prog_loader.sv | 195 +++++++++++++++++++
 tb/tb_chip8_prog_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants and the program-loader state encoding.
// The CPU core and the loader both take their memory geometry from here.
package chip8_pkg;

   localparam int unsigned MEM_DEPTH = 3328;
   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned RESET_PC  = 0;

   // Frame length and byte counter width.
   localparam int unsigned LEN_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CSUM,
      ST_FILL,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   // Pointer increment that wraps back to address 0 after the last memory byte.
   function automatic logic [LEN_W-1:0] wrap_inc(input logic [LEN_W-1:0] ptr,
                                                 input logic [LEN_W-1:0] depth);
      return (ptr == depth - LEN_W'(1)) ? '0 : ptr + LEN_W'(1);
   endfunction

endpackage

// File: rtl/chip8_csum8.sv
// Running mod-256 byte sum with synchronous clear, used to verify loaded images.
module chip8_csum8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/chip8_prog_loader.sv
// Loads a framed program image (length, payload, checksum) into CHIP-8 program
// memory, zero-fills the remainder and holds the CPU until the image is verified.
module chip8_prog_loader #(
   parameter int unsigned MEM_DEPTH = chip8_pkg::MEM_DEPTH,
   parameter int unsigned ADDR_W    = chip8_pkg::ADDR_W,
   parameter int unsigned BASE_ADDR = chip8_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              err
);

   import chip8_pkg::*;

   localparam int unsigned EXT_W = LEN_W + 1;
   localparam logic [EXT_W-1:0] MAX_LEN = EXT_W'(MEM_DEPTH - BASE_ADDR);
   localparam logic [LEN_W-1:0] DEPTH_C = LEN_W'(MEM_DEPTH);
   localparam logic [LEN_W-1:0] BASE_C  = LEN_W'(BASE_ADDR);

   loader_state_t     state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [LEN_W-1:0]  fill_ptr_q, fill_ptr_d;
   logic [LEN_W-1:0]  fill_left_q, fill_left_d;

   logic              in_ready_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [7:0]        mem_wdata_d;
   logic              cpu_hold_d;
   logic              load_done_d;
   logic              err_d;

   logic              xfer_c;
   logic              csum_clr;
   logic              csum_en;
   logic [7:0]        csum;
   logic [LEN_W-1:0]  len_new;
   logic [LEN_W-1:0]  fill_start_raw;
   logic [LEN_W-1:0]  fill_start;
   logic [LEN_W-1:0]  fill_cnt;

   assign xfer_c         = in_valid & in_ready;
   assign len_new        = {len_q[LEN_W-1:8], in_data};
   assign fill_start_raw = BASE_C + len_q;
   // A payload that ends exactly at the top of memory resumes filling at 0.
   assign fill_start     = (fill_start_raw == DEPTH_C) ? '0 : fill_start_raw;
   assign fill_cnt       = DEPTH_C - len_q;

   chip8_csum8 u_csum (
      .clk (clk),
      .rst (rst),
      .clr (csum_clr),
      .en  (csum_en),
      .din (in_data),
      .sum (csum)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      count_d     = count_q;
      fill_ptr_d  = fill_ptr_q;
      fill_left_d = fill_left_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      csum_clr    = 1'b0;
      csum_en     = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d  = ST_LEN_HI;
               len_d    = '0;
               count_d  = '0;
               csum_clr = 1'b1;
            end
         end

         ST_LEN_HI: begin
            if (xfer_c) begin
               len_d   = {in_data, len_q[7:0]};
               state_d = ST_LEN_LO;
            end
         end

         ST_LEN_LO: begin
            if (xfer_c) begin
               len_d = len_new;
               if (len_new == '0 || {1'b0, len_new} > MAX_LEN) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            if (xfer_c) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_W'(BASE_C + count_q);
               mem_wdata_d = in_data;
               csum_en     = 1'b1;
               count_d     = count_q + LEN_W'(1);
               if (count_q == len_q - LEN_W'(1)) begin
                  state_d = ST_CSUM;
               end
            end
         end

         ST_CSUM: begin
            if (xfer_c) begin
               if (in_data != csum) begin
                  state_d = ST_ERROR;
               end else if (fill_cnt == '0) begin
                  state_d = ST_DONE;
               end else begin
                  // First fill write is issued here so writes line up with FILL.
                  state_d     = ST_FILL;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ADDR_W'(fill_start);
                  mem_wdata_d = 8'h00;
                  fill_ptr_d  = wrap_inc(fill_start, DEPTH_C);
                  fill_left_d = fill_cnt - LEN_W'(1);
               end
            end
         end

         ST_FILL: begin
            if (fill_left_q == '0) begin
               state_d = ST_DONE;
            end else begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_W'(fill_ptr_q);
               mem_wdata_d = 8'h00;
               fill_ptr_d  = wrap_inc(fill_ptr_q, DEPTH_C);
               fill_left_d = fill_left_q - LEN_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d  = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                    (state_d == ST_DATA)   || (state_d == ST_CSUM);
      cpu_hold_d  = (state_d != ST_DONE);
      load_done_d = (state_d == ST_DONE);
      err_d       = (state_d == ST_ERROR);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         count_q     <= '0;
         fill_ptr_q  <= '0;
         fill_left_q <= '0;
         in_ready    <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cpu_hold    <= 1'b1;
         load_done   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         count_q     <= count_d;
         fill_ptr_q  <= fill_ptr_d;
         fill_left_q <= fill_left_d;
         in_ready    <= in_ready_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         cpu_hold    <= cpu_hold_d;
         load_done   <= load_done_d;
         err         <= err_d;
      end
   end

endmodule

// File: tb/tb_chip8_prog_loader.sv
// Scoreboard bench for chip8_prog_loader: stimulus queues expected memory writes,
// a negedge monitor pops and compares every mem_we cycle.
module tb_chip8_prog_loader;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        err;

   int          vectors     = 0;
   int          miscompares = 0;
   int          wr_count    = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  payload[$];

   chip8_prog_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Monitor: every write the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         wr_count++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                     mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
               miscompares++;
               $display("FAIL mem_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        mem_addr, mem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input int addr, input logic [7:0] data);
      wr_t w;
      w.addr = 12'(addr);
      w.data = data;
      exp_q.push_back(w);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int n = 0;
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_ready", 32'(in_ready), 32'd1);
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_done_clr", 32'(load_done), 32'd0);
      check("start_err_clr", 32'(err), 32'd0);
   endtask

   // Sends length, queued payload and checksum; optionally expects the zero fill.
   task automatic run_frame(input logic [15:0] len, input logic [7:0] cs,
                            input int gap_max, input bit fill);
      send_byte(len[15:8], gap_max);
      send_byte(len[7:0], gap_max);
      for (int i = 0; i < payload.size(); i++) begin
         push_wr(i, payload[i]);
         send_byte(payload[i], gap_max);
      end
      if (fill) begin
         for (int a = int'(len); a < 3328; a++) push_wr(a, 8'h00);
      end
      send_byte(cs, gap_max);
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!load_done && !err && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
      check({tag, "_load_done"}, 32'(load_done), 32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
   endtask

   task automatic good_load(input string tag, input int gap_max);
      int w0;
      w0 = wr_count;
      payload = '{8'h60, 8'h05, 8'h70, 8'h01};
      pulse_start();
      run_frame(16'd4, 8'hD6, gap_max, 1'b1);
      wait_end(4000);
      check({tag, "_load_done"}, 32'(load_done), 32'd1);
      check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
      check({tag, "_queue"},     32'(exp_q.size()), 32'd0);
      check({tag, "_writes"},    32'(wr_count - w0), 32'd3328);
   endtask

   initial begin
      int         w0;
      logic [7:0] sum;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Nominal load: 60 05 70 01, sum D6, then zeros at 4..3327.
      good_load("good", 0);

      // Bad checksum: payload written, no fill, error sticky, then retry.
      w0 = wr_count;
      payload = '{8'h60, 8'h05, 8'h70, 8'h01};
      pulse_start();
      run_frame(16'd4, 8'h77, 0, 1'b0);
      check("badcs_err",  32'(err),       32'd1);
      check("badcs_hold", 32'(cpu_hold),  32'd1);
      check("badcs_done", 32'(load_done), 32'd0);
      check("badcs_rdy",  32'(in_ready),  32'd0);
      repeat (10) @(posedge clk);
      #1;
      check("badcs_writes", 32'(wr_count - w0), 32'd4);
      check("badcs_err_sticky", 32'(err), 32'd1);
      good_load("retry", 0);

      // Zero length and one-past-full length both fail right after LEN_LO.
      for (int k = 0; k < 2; k++) begin
         logic [15:0] bad_len;
         bad_len = (k == 0) ? 16'd0 : 16'd3329;
         w0 = wr_count;
         pulse_start();
         send_byte(bad_len[15:8], 0);
         send_byte(bad_len[7:0], 0);
         check("badlen_err",  32'(err),      32'd1);
         check("badlen_hold", 32'(cpu_hold), 32'd1);
         check("badlen_rdy",  32'(in_ready), 32'd0);
         repeat (5) @(posedge clk);
         #1;
         check("badlen_writes", 32'(wr_count - w0), 32'd0);
      end

      // Full image: 3328 random bytes, no fill cycles, DONE straight from CSUM.
      w0 = wr_count;
      payload.delete();
      sum = 8'h00;
      for (int i = 0; i < 3328; i++) begin
         payload.push_back(8'($urandom_range(255, 0)));
         sum = sum + payload[i];
      end
      pulse_start();
      run_frame(16'd3328, sum, 0, 1'b0);
      check("full_done",   32'(load_done), 32'd1);
      check("full_hold",   32'(cpu_hold),  32'd0);
      check("full_err",    32'(err),       32'd0);
      check("full_writes", 32'(wr_count - w0), 32'd3328);

      // Random valid gaps: A1 B2 C3 D4 E5, sum CF.
      w0 = wr_count;
      payload = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      pulse_start();
      run_frame(16'd5, 8'hCF, 3, 1'b1);
      wait_end(4000);
      check("gap_done",   32'(load_done), 32'd1);
      check("gap_err",    32'(err),       32'd0);
      check("gap_queue",  32'(exp_q.size()), 32'd0);
      check("gap_writes", 32'(wr_count - w0), 32'd3328);
      good_load("gap_nominal", 2);

      // Reset while the second payload write is on the bus.
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      push_wr(0, 8'h60);
      send_byte(8'h60, 0);
      send_byte(8'h05, 0);
      check("midrst_we_before", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      check("midrst_queue", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      good_load("after_rst", 0);

      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
